// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug-slave command path.
// - Virtual IR channel codes used to index take_action / take_no_action.
// - Default widths for the shift register, the virtual IR and the action bit.
package nios2_debug_pkg;

   localparam int unsigned SR_W_DEF    = 38;
   localparam int unsigned IR_W_DEF    = 2;
   localparam int unsigned ACT_BIT_DEF = 34;

   typedef enum logic [1:0] {
      IR_OCIMEM    = 2'd0,
      IR_TRACEMEM  = 2'd1,
      IR_BREAK     = 2'd2,
      IR_TRACECTRL = 2'd3
   } ir_code_e;

endpackage

// File: rtl/nios2_debug_sync_rise.sv
// Level synchroniser with rising-edge detector.
// Ports:
//   clk     - destination clock
//   reset_n - async active-low reset
//   level   - asynchronous level from the TCK domain
//   rise    - one-cycle pulse per synchronised low->high transition
// The detector only arms once a genuine low level has travelled through the
// chain after reset, so a level held high across reset never produces a pulse.
module nios2_debug_sync_rise #(
   parameter int unsigned NSYNC = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic level,
   output logic rise
);

   logic [NSYNC-1:0] sync_r;
   logic [NSYNC-1:0] vld_r;
   logic             sync_d_r;
   logic             armed_r;

   // Synchroniser chain, delay flop and arming state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r   <= '0;
         vld_r    <= '0;
         sync_d_r <= 1'b0;
         armed_r  <= 1'b0;
      end else begin
         sync_r   <= {sync_r[NSYNC-2:0], level};
         // vld_r marks when sync_r carries real samples rather than reset zeros
         vld_r    <= {vld_r[NSYNC-2:0], 1'b1};
         sync_d_r <= sync_r[NSYNC-1];
         armed_r  <= armed_r | (vld_r[NSYNC-1] & ~sync_r[NSYNC-1]);
      end
   end

   assign rise = sync_r[NSYNC-1] & ~sync_d_r & armed_r;

endmodule

// File: rtl/nios2_debug_slave_cmd_queue.sv
// Sysclk-side command queue for the Nios II debug slave.
// Ports:
//   clk, reset_n          - system clock, async active-low reset
//   ir_in, sr             - TCK-domain virtual IR and shift register
//   vs_uir, vs_udr        - TCK-domain update-IR / update-DR levels
//   cmd_ready             - consumer accepts the head command
//   ovf_clr               - clears the sticky overflow flag
//   cmd_valid, jdo, cmd_ir- head command of the FIFO
//   take_action           - one-cycle pulse per pop, one-hot by IR, jdo[ACT_BIT]=1
//   take_no_action        - same, jdo[ACT_BIT]=0
//   level                 - FIFO occupancy
//   overflow              - sticky, an update-DR was dropped on a full FIFO
module nios2_debug_slave_cmd_queue
   import nios2_debug_pkg::*;
#(
   parameter  int unsigned SR_W    = SR_W_DEF,
   parameter  int unsigned IR_W    = IR_W_DEF,
   parameter  int unsigned NSYNC   = 2,
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned ACT_BIT = ACT_BIT_DEF,
   localparam int unsigned NUM_CH  = 2**IR_W,
   localparam int unsigned LVL_W   = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [SR_W-1:0]   sr,
   input  logic              vs_uir,
   input  logic              vs_udr,
   input  logic              cmd_ready,
   input  logic              ovf_clr,
   output logic              cmd_valid,
   output logic [SR_W-1:0]   jdo,
   output logic [IR_W-1:0]   cmd_ir,
   output logic [NUM_CH-1:0] take_action,
   output logic [NUM_CH-1:0] take_no_action,
   output logic [LVL_W-1:0]  level,
   output logic              overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = IR_W + SR_W;

   logic              uir_rise_s;
   logic              udr_rise_s;
   logic [IR_W-1:0]   ir_q_r;
   logic [EW-1:0]     mem_r [DEPTH];
   logic [PW-1:0]     wr_ptr_r;
   logic [PW-1:0]     rd_ptr_r;
   logic [EW-1:0]     head_s;
   logic              empty_s;
   logic              full_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic              overflow_r;
   logic [NUM_CH-1:0] ch_onehot_s;
   logic [NUM_CH-1:0] take_action_r;
   logic [NUM_CH-1:0] take_no_action_r;

   nios2_debug_sync_rise #(.NSYNC(NSYNC)) u_sync_uir (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (vs_uir),
      .rise    (uir_rise_s)
   );

   nios2_debug_sync_rise #(.NSYNC(NSYNC)) u_sync_udr (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (vs_udr),
      .rise    (udr_rise_s)
   );

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s   = ~empty_s & cmd_ready;
   // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
   assign push_s  = udr_rise_s & (~full_s | pop_s);
   assign drop_s  = udr_rise_s & full_s & ~pop_s;
   assign head_s  = mem_r[rd_ptr_r[AW-1:0]];

   // One-hot channel select for the entry being popped.
   always_comb begin
      ch_onehot_s = '0;
      ch_onehot_s[head_s[EW-1:SR_W]] = 1'b1;
   end

   // Capture the virtual IR on each update-IR; the push below sees the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_q_r <= '0;
      end else if (uir_rise_s) begin
         ir_q_r <= ir_in;
      end
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {ir_q_r, sr};
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
      end
   end

   // Sticky overflow; a new drop beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (ovf_clr) begin
         overflow_r <= 1'b0;
      end
   end

   // Per-channel action pulses, one cycle after the pop that produced them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         take_action_r    <= '0;
         take_no_action_r <= '0;
      end else begin
         take_action_r    <= (pop_s &  head_s[ACT_BIT]) ? ch_onehot_s : '0;
         take_no_action_r <= (pop_s & ~head_s[ACT_BIT]) ? ch_onehot_s : '0;
      end
   end

   assign cmd_valid      = ~empty_s;
   assign jdo            = head_s[SR_W-1:0];
   assign cmd_ir         = head_s[EW-1:SR_W];
   assign take_action    = take_action_r;
   assign take_no_action = take_no_action_r;
   assign level          = LVL_W'(wr_ptr_r - rd_ptr_r);
   assign overflow       = overflow_r;

endmodule
